// File: rtl/energy_monitor_ctrl.sv
// energy_monitor_ctrl
// Sequences one total-Ising-energy computation. A spin vector (and optionally
// a new h-scaling factor) is accepted in IDLE, then DATASPIN weight/bias rows
// are streamed in order j = 0..DATASPIN-1. Each accepted row is registered
// onto the calc_* outputs feeding an external combinational per-spin energy
// calculator. The returned partial energy is accumulated one cycle later.
// The signed total is offered on a valid/ready handshake.
//
// Ports
//   clk_i, rst_i                        clock, synchronous active-high reset
//   config_valid_i/ready_o/hscaling_i   h-scaling config handshake (IDLE only)
//   spin_valid_i/ready_o, spin_i        spin vector handshake, starts a run
//   weight_valid_i/ready_o, weight_i,
//   hbias_i                             row stream (J row j and h_j)
//   calc_*_o, calc_energy_i             calculator interface
//   energy_valid_o/ready_i, energy_o    signed total energy result
//   busy_o                              high whenever not IDLE
//
// state   | meaning
// S_IDLE  | waiting for spin vector; config may be updated
// S_ACCUM | issuing rows to calculator and accumulating partials
// S_DONE  | total presented on energy_o until consumer accepts
module energy_monitor_ctrl #(
  parameter int BITJ             = 4,
  parameter int BITH             = 4,
  parameter int DATASPIN         = 256,
  parameter int SCALING_BIT      = 5,
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int ENERGY_TOTAL_BIT = 32,
  parameter int DATAJ            = DATASPIN * BITJ
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        config_valid_i,
  output logic                        config_ready_o,
  input  logic [SCALING_BIT-1:0]      config_hscaling_i,
  input  logic                        spin_valid_i,
  output logic                        spin_ready_o,
  input  logic [DATASPIN-1:0]         spin_i,
  input  logic                        weight_valid_i,
  output logic                        weight_ready_o,
  input  logic [DATAJ-1:0]            weight_i,
  input  logic [BITH-1:0]             hbias_i,
  output logic [DATASPIN-1:0]         calc_spin_vector_o,
  output logic                        calc_current_spin_o,
  output logic [DATAJ-1:0]            calc_weight_o,
  output logic [BITH-1:0]             calc_hbias_o,
  output logic [SCALING_BIT-1:0]      calc_hscaling_o,
  input  logic [LOCAL_ENERGY_BIT-1:0] calc_energy_i,
  output logic                        energy_valid_o,
  input  logic                        energy_ready_i,
  output logic [ENERGY_TOTAL_BIT-1:0] energy_o,
  output logic                        busy_o
);

  localparam int CNT_W = $clog2(DATASPIN + 1);
  localparam int IDX_W = (DATASPIN > 1) ? $clog2(DATASPIN) : 1;
  localparam int EXT_W = ENERGY_TOTAL_BIT - LOCAL_ENERGY_BIT;
  localparam logic [CNT_W-1:0]       ROWS         = CNT_W'(DATASPIN);
  localparam logic [CNT_W-1:0]       LAST_ROW     = CNT_W'(DATASPIN - 1);
  localparam logic [SCALING_BIT-1:0] HSCALE_RESET = SCALING_BIT'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SCALING_BIT-1:0]      hscaling_q;
  logic [DATASPIN-1:0]         spin_q;
  logic [CNT_W-1:0]            issued_q;
  logic [CNT_W-1:0]            accumulated_q;
  logic                        stage_valid_q;
  logic [ENERGY_TOTAL_BIT-1:0] acc_q;
  logic [ENERGY_TOTAL_BIT-1:0] energy_q;
  logic                        cur_spin_q;
  logic [DATAJ-1:0]            weight_q;
  logic [BITH-1:0]             hbias_q;

  logic                        cfg_hs;
  logic                        spin_hs;
  logic                        row_hs;
  logic [ENERGY_TOTAL_BIT-1:0] acc_sum;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    config_ready_o = 1'b0;
    spin_ready_o   = 1'b0;
    weight_ready_o = 1'b0;
    energy_valid_o = 1'b0;
    busy_o         = 1'b1;
    case (state_q)
      S_IDLE: begin
        config_ready_o = 1'b1;
        spin_ready_o   = 1'b1;
        busy_o         = 1'b0;
        if (spin_valid_i) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        weight_ready_o = (issued_q < ROWS);
        // Final partial is being summed this cycle.
        if (stage_valid_q && (accumulated_q == LAST_ROW)) state_d = S_DONE;
      end
      S_DONE: begin
        energy_valid_o = 1'b1;
        if (energy_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_hs  = config_valid_i & config_ready_o;
  assign spin_hs = spin_valid_i & spin_ready_o;
  assign row_hs  = weight_valid_i & weight_ready_o;
  assign acc_sum = acc_q + {{EXT_W{calc_energy_i[LOCAL_ENERGY_BIT-1]}}, calc_energy_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hscaling_q    <= HSCALE_RESET;
      spin_q        <= '0;
      issued_q      <= '0;
      accumulated_q <= '0;
      stage_valid_q <= 1'b0;
      acc_q         <= '0;
      energy_q      <= '0;
      cur_spin_q    <= 1'b0;
      weight_q      <= '0;
      hbias_q       <= '0;
    end else begin
      if (cfg_hs) hscaling_q <= config_hscaling_i;
      if (spin_hs) begin
        spin_q        <= spin_i;
        acc_q         <= '0;
        issued_q      <= '0;
        accumulated_q <= '0;
      end
      // row_hs is only possible in S_ACCUM, so this also idles the stage elsewhere.
      stage_valid_q <= row_hs;
      if (row_hs) begin
        weight_q   <= weight_i;
        hbias_q    <= hbias_i;
        cur_spin_q <= spin_q[issued_q[IDX_W-1:0]];
        issued_q   <= issued_q + 1'b1;
      end
      if ((state_q == S_ACCUM) && stage_valid_q) begin
        acc_q         <= acc_sum;
        accumulated_q <= accumulated_q + 1'b1;
        // energy_o holds the last completed total across the next run.
        if (accumulated_q == LAST_ROW) energy_q <= acc_sum;
      end
    end
  end

  assign calc_spin_vector_o  = spin_q;
  assign calc_current_spin_o = cur_spin_q;
  assign calc_weight_o       = weight_q;
  assign calc_hbias_o        = hbias_q;
  assign calc_hscaling_o     = hscaling_q;
  assign energy_o            = energy_q;

endmodule

// File: tb/tb_energy_monitor_ctrl.sv
module tb_energy_monitor_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  longint q_s[$];
  longint q_f[$];

  // ---------------- small instance (DATASPIN = 4) ----------------
  logic        s_cfg_valid = 0, s_cfg_ready;
  logic [4:0]  s_cfg = 5'd1;
  logic        s_spin_valid = 0, s_spin_ready;
  logic [3:0]  s_spin = '0;
  logic        s_w_valid = 0, s_w_ready;
  logic [15:0] s_w = '0;
  logic [3:0]  s_h = '0;
  logic [3:0]  s_c_sv;
  logic        s_c_cs;
  logic [15:0] s_c_w;
  logic [3:0]  s_c_h;
  logic [4:0]  s_c_sc;
  logic [15:0] s_c_e;
  logic        s_e_valid, s_e_ready = 0;
  logic [31:0] s_energy;
  logic        s_busy;

  energy_monitor_ctrl #(.BITJ(4), .BITH(4), .DATASPIN(4), .SCALING_BIT(5),
                        .LOCAL_ENERGY_BIT(16), .ENERGY_TOTAL_BIT(32)) u_small (
    .clk_i(clk), .rst_i(rst),
    .config_valid_i(s_cfg_valid), .config_ready_o(s_cfg_ready), .config_hscaling_i(s_cfg),
    .spin_valid_i(s_spin_valid), .spin_ready_o(s_spin_ready), .spin_i(s_spin),
    .weight_valid_i(s_w_valid), .weight_ready_o(s_w_ready), .weight_i(s_w), .hbias_i(s_h),
    .calc_spin_vector_o(s_c_sv), .calc_current_spin_o(s_c_cs), .calc_weight_o(s_c_w),
    .calc_hbias_o(s_c_h), .calc_hscaling_o(s_c_sc), .calc_energy_i(s_c_e),
    .energy_valid_o(s_e_valid), .energy_ready_i(s_e_ready), .energy_o(s_energy),
    .busy_o(s_busy));

  // ---------------- full-scale instance (DATASPIN = 256) ----------------
  logic          f_cfg_valid = 0, f_cfg_ready;
  logic [4:0]    f_cfg = 5'd1;
  logic          f_spin_valid = 0, f_spin_ready;
  logic [255:0]  f_spin = '0;
  logic          f_w_valid = 0, f_w_ready;
  logic [1023:0] f_w = '0;
  logic [3:0]    f_h = '0;
  logic [255:0]  f_c_sv;
  logic          f_c_cs;
  logic [1023:0] f_c_w;
  logic [3:0]    f_c_h;
  logic [4:0]    f_c_sc;
  logic [15:0]   f_c_e;
  logic          f_e_valid, f_e_ready = 0;
  logic [31:0]   f_energy;
  logic          f_busy;

  energy_monitor_ctrl #(.BITJ(4), .BITH(4), .DATASPIN(256), .SCALING_BIT(5),
                        .LOCAL_ENERGY_BIT(16), .ENERGY_TOTAL_BIT(32)) u_full (
    .clk_i(clk), .rst_i(rst),
    .config_valid_i(f_cfg_valid), .config_ready_o(f_cfg_ready), .config_hscaling_i(f_cfg),
    .spin_valid_i(f_spin_valid), .spin_ready_o(f_spin_ready), .spin_i(f_spin),
    .weight_valid_i(f_w_valid), .weight_ready_o(f_w_ready), .weight_i(f_w), .hbias_i(f_h),
    .calc_spin_vector_o(f_c_sv), .calc_current_spin_o(f_c_cs), .calc_weight_o(f_c_w),
    .calc_hbias_o(f_c_h), .calc_hscaling_o(f_c_sc), .calc_energy_i(f_c_e),
    .energy_valid_o(f_e_valid), .energy_ready_i(f_e_ready), .energy_o(f_energy),
    .busy_o(f_busy));

  // Calculator models: E_j = s_j * (sum_i J_ji * s_i + h_j * scale)
  function automatic logic [15:0] calc4(input logic [3:0] sv, input logic cs,
                                        input logic [15:0] w, input logic [3:0] h,
                                        input logic [4:0] sc);
    int sum, jv, hv;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      jv = $signed(w[i*4 +: 4]);
      sum += sv[i] ? jv : -jv;
    end
    hv = $signed(h);
    sum += hv * int'(sc);
    if (!cs) sum = -sum;
    return sum[15:0];
  endfunction

  function automatic logic [15:0] calc256(input logic [255:0] sv, input logic cs,
                                          input logic [1023:0] w, input logic [3:0] h,
                                          input logic [4:0] sc);
    int sum, jv, hv;
    sum = 0;
    for (int i = 0; i < 256; i++) begin
      jv = $signed(w[i*4 +: 4]);
      sum += sv[i] ? jv : -jv;
    end
    hv = $signed(h);
    sum += hv * int'(sc);
    if (!cs) sum = -sum;
    return sum[15:0];
  endfunction

  assign s_c_e = calc4(s_c_sv, s_c_cs, s_c_w, s_c_h, s_c_sc);
  assign f_c_e = calc256(f_c_sv, f_c_cs, f_c_w, f_c_h, f_c_sc);

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare every accepted total against the queue.
  always @(negedge clk) begin
    longint e;
    if (s_e_valid && s_e_ready) begin
      n_tests++;
      if (q_s.size() == 0) begin
        n_fail++;
        $display("FAIL small_energy: unexpected total %0d, expected none", $signed(s_energy));
      end else begin
        e = q_s.pop_front();
        if (longint'($signed(s_energy)) != e) begin
          n_fail++;
          $display("FAIL small_energy: got %0d, expected %0d", $signed(s_energy), e);
        end
      end
    end
    if (f_e_valid && f_e_ready) begin
      n_tests++;
      if (q_f.size() == 0) begin
        n_fail++;
        $display("FAIL full_energy: unexpected total %0d, expected none", $signed(f_energy));
      end else begin
        e = q_f.pop_front();
        if (longint'($signed(f_energy)) != e) begin
          n_fail++;
          $display("FAIL full_energy: got %0d, expected %0d", $signed(f_energy), e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_small_reset(input string tag);
    check({tag, " busy"}, s_busy, 0);
    check({tag, " config_ready"}, s_cfg_ready, 1);
    check({tag, " spin_ready"}, s_spin_ready, 1);
    check({tag, " weight_ready"}, s_w_ready, 0);
    check({tag, " energy_valid"}, s_e_valid, 0);
    check({tag, " energy_o"}, s_energy, 0);
    check({tag, " calc_hscaling"}, s_c_sc, 1);
    check({tag, " calc_spin_vector"}, s_c_sv, 0);
    check({tag, " calc_current_spin"}, s_c_cs, 0);
    check({tag, " calc_weight"}, s_c_w, 0);
    check({tag, " calc_hbias"}, s_c_h, 0);
  endtask

  task automatic run_small(input string tag, input logic [3:0] spins, input logic [3:0] h,
                           input logic [4:0] sc, input int gap1, input int gap3,
                           input int hold, input longint exp_e);
    int cyc, gap;
    q_s.push_back(exp_e);
    check({tag, " spin_ready"}, s_spin_ready, 1);
    s_spin_valid = 1; s_spin = spins; s_cfg_valid = 1; s_cfg = sc;
    tick();
    s_spin_valid = 0; s_cfg_valid = 0;
    cyc = 1;
    for (int j = 0; j < 4; j++) begin
      gap = (j == 1) ? gap1 : ((j == 3) ? gap3 : 0);
      for (int g = 0; g < gap; g++) begin
        s_w_valid = 0;
        check({tag, " gap weight_ready"}, s_w_ready, 1);
        tick(); cyc++;
      end
      s_w_valid = 1; s_w = 16'h1111; s_h = h;
      tick(); cyc++;
    end
    s_w_valid = 0;
    while (!s_e_valid && cyc < 40) begin
      tick(); cyc++;
    end
    if (!s_e_valid) check({tag, " energy_valid timeout"}, 0, 1);
    if (gap1 == 0 && gap3 == 0) check({tag, " latency"}, cyc, 6);
    for (int k = 0; k < hold; k++) begin
      check({tag, " hold energy_valid"}, s_e_valid, 1);
      check({tag, " hold energy_o"}, $signed(s_energy), exp_e);
      check({tag, " hold spin_ready"}, s_spin_ready, 0);
      check({tag, " hold busy"}, s_busy, 1);
      tick();
    end
    s_e_ready = 1;
    tick();
    s_e_ready = 0;
    check({tag, " idle after handshake"}, s_busy, 0);
    check({tag, " energy_o retained"}, $signed(s_energy), exp_e);
  endtask

  initial begin
    int cyc;
    rst = 1;
    tick(); tick();
    rst = 0;
    check_small_reset("reset");
    check("reset full spin_ready", f_spin_ready, 1);
    check("reset full calc_hscaling", f_c_sc, 1);

    s_w_valid = 1;
    check("idle row ignored", s_w_ready, 0);
    tick();
    s_w_valid = 0;
    check("idle row no run", s_busy, 0);

    run_small("t1", 4'b1111, 4'h0, 5'd1, 0, 0, 0, 16);
    run_small("t2", 4'b0001, 4'hF, 5'd2, 0, 0, 0, 8);
    run_small("t3", 4'b1111, 4'h0, 5'd1, 3, 3, 0, 16);
    run_small("t4", 4'b1111, 4'h0, 5'd1, 0, 0, 5, 16);

    // Abort a run after row 2 has been issued.
    s_spin_valid = 1; s_spin = 4'b0001; s_cfg_valid = 1; s_cfg = 5'd2;
    tick();
    s_spin_valid = 0; s_cfg_valid = 0;
    for (int j = 0; j < 3; j++) begin
      s_w_valid = 1; s_w = 16'h1111; s_h = 4'hF;
      tick();
    end
    s_w_valid = 0;
    check("t5 busy before reset", s_busy, 1);
    rst = 1;
    tick();
    rst = 0;
    check_small_reset("t5 after reset");
    run_small("t5 rerun", 4'b0001, 4'hF, 5'd2, 0, 0, 0, 8);

    // Full scale: J=-8, spins all -1, h=+7, scale=16 -> 256 * -2160
    q_f.push_back(-64'sd552960);
    f_spin_valid = 1; f_spin = '0; f_cfg_valid = 1; f_cfg = 5'd16;
    tick();
    f_spin_valid = 0; f_cfg_valid = 0;
    cyc = 1;
    for (int j = 0; j < 256; j++) begin
      f_w_valid = 1; f_w = {256{4'h8}}; f_h = 4'h7;
      tick(); cyc++;
    end
    f_w_valid = 0;
    while (!f_e_valid && cyc < 400) begin
      tick(); cyc++;
    end
    if (!f_e_valid) check("t6 energy_valid timeout", 0, 1);
    check("t6 latency", cyc, 258);
    check("t6 sign bit", f_energy[31], 1);
    f_e_ready = 1;
    tick();
    f_e_ready = 0;
    check("t6 idle after handshake", f_busy, 0);

    tick();
    check("small queue drained", q_s.size(), 0);
    check("full queue drained", q_f.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/energy_monitor_ctrl.md
Name: energy_monitor_ctrl

Overview:
Sequencer that computes the total Ising energy of one spin configuration using the combinational per-spin energy calculator. It accepts a spin vector and an h-scaling config, then streams DATASPIN weight/bias rows in order. For each row it drives the calculator inputs from registers and accumulates the returned partial energy. It returns the signed total through a valid/ready handshake, and sits between the weight/spin memories and the energy-monitor consumer.

Parameters:
BITJ, 4, bit precision of J entries
BITH, 4, bit precision of h
DATASPIN, 256, number of spins (rows per run)
SCALING_BIT, 5, width of h scaling factor
LOCAL_ENERGY_BIT, 16, width of the calculator partial-energy result
ENERGY_TOTAL_BIT, 32, width of the accumulated total; must be >= LOCAL_ENERGY_BIT + $clog2(DATASPIN)
DATAJ, DATASPIN*BITJ, width of one weight row

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
config_valid_i  in  1  hscaling config valid
config_ready_o  out  1  config accepted (high in IDLE only)
config_hscaling_i  in  SCALING_BIT  h scaling factor (1/2/4/8/16)
spin_valid_i  in  1  spin vector valid; starts a run
spin_ready_o  out  1  high in IDLE only
spin_i  in  DATASPIN  spin vector (1 = +1, 0 = -1)
weight_valid_i  in  1  row valid
weight_ready_o  out  1  row accepted
weight_i  in  DATAJ  J row j
hbias_i  in  BITH  signed h_j
calc_spin_vector_o  out  DATASPIN  to calculator
calc_current_spin_o  out  1  spin_j to calculator
calc_weight_o  out  DATAJ  to calculator
calc_hbias_o  out  BITH  to calculator
calc_hscaling_o  out  SCALING_BIT  to calculator
calc_energy_i  in  LOCAL_ENERGY_BIT  signed partial energy from calculator (combinational)
energy_valid_o  out  1  total valid
energy_ready_i  in  1  consumer ready
energy_o  out  ENERGY_TOTAL_BIT  signed total energy
busy_o  out  1  high when not IDLE

Behaviour:
- Reset values: all outputs 0 except config_ready_o=1, spin_ready_o=1, calc_hscaling_o=1. FSM goes to IDLE. Accumulator, row counter and stage-valid clear. Reset mid-run discards all in-flight rows.
- FSM IDLE -> ACCUM on spin handshake. ACCUM -> DONE once the last row has accumulated. DONE -> IDLE on energy handshake.
- IDLE:
  - Config handshake latches hscaling_reg.
  - Spin handshake latches spin_reg, clears acc and issued/accumulated counters.
  - Config and spin in the same cycle: the new hscaling applies to that run.
- ACCUM, issue stage:
  - weight_ready_o = (issued < DATASPIN).
  - On a row handshake, capture weight_i, hbias_i and spin_reg[issued] into the calc_* registers, set stage_valid, and increment issued.
  - calc_spin_vector_o = spin_reg and calc_hscaling_o = hscaling_reg throughout the run.
  - Rows are in order j = 0..DATASPIN-1. weight_valid_i gaps stall issue without corrupting state.
- ACCUM, accumulate stage:
  - Each cycle stage_valid=1, acc <= acc + sign_extend(calc_energy_i) and accumulated increments.
  - stage_valid clears if no new row issued.
  - Throughput is 1 row/cycle.
- Arithmetic: two's complement. acc wraps modulo 2^ENERGY_TOTAL_BIT; the parameter constraint prevents overflow for legal inputs. No halving of the symmetric double count; scaling is the consumer's job.
- DONE:
  - energy_valid_o=1 and energy_o=acc, both held stable until energy_ready_i.
  - energy_o keeps its value after the handshake until the next completion.
- Latency with no stalls: spin handshake in cycle T0, rows accepted T1..TN, energy_valid_o first high in cycle T0+DATASPIN+2.
- Rows presented outside ACCUM are ignored (weight_ready_o=0). Spin/config are never accepted outside IDLE.

Test Plan:
1. DATASPIN=4, spin_i=4'b1111, all J=+1, h=0, scale=1 -> each partial = 4, energy_o=16; energy_valid_o first high 6 cycles after the spin handshake.
2. DATASPIN=4, spin_i=4'b0001, all J=+1, h=-1, config scale=2 in the same cycle as spin -> partials -4,+4,+4,+4, energy_o=8.
3. Scenario 1 with weight_valid_i deasserted for 3 cycles before rows 1 and 3 -> energy_o=16; weight_ready_o stays high and issued does not advance during the gaps.
4. energy_ready_i held low 5 cycles in DONE -> energy_valid_o=1 and energy_o stable throughout; spin_ready_o=0 and busy_o=1 until the handshake.
5. rst_i asserted after row 2 is issued -> next cycle state IDLE, all outputs at reset values. A fresh scenario-2 run then yields 8.
6. Full-scale DATASPIN=256, all J=-8, all spins 0, h=+7, scale=16 -> compare against the reference model, including negative-total sign extension.
